// File: rtl/pe_stream_ctrl.sv
// PE stream controller: fetches filter/ifmap/ipsum words from the global
// buffer, streams them into a processing element over valid/ready ports,
// and writes the PE's partial sums back to the buffer, one pass per output
// row (F+1 passes in total).
module pe_stream_ctrl #(
    parameter int DATA_BITS   = 32,
    parameter int ADDR_BITS   = 12,
    parameter int CONFIG_SIZE = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CONFIG_SIZE-1:0] cfg,
    input  logic [ADDR_BITS-1:0]   filter_base,
    input  logic [ADDR_BITS-1:0]   ifmap_base,
    input  logic [ADDR_BITS-1:0]   ipsum_base,
    input  logic [ADDR_BITS-1:0]   opsum_base,
    output logic                   busy,
    output logic                   done,
    output logic                   pe_en,
    output logic [CONFIG_SIZE-1:0] pe_config,
    output logic                   rd_en,
    output logic [ADDR_BITS-1:0]   rd_addr,
    input  logic [DATA_BITS-1:0]   rd_data,
    output logic                   wr_en,
    output logic [ADDR_BITS-1:0]   wr_addr,
    output logic [DATA_BITS-1:0]   wr_data,
    output logic [DATA_BITS-1:0]   filter_data,
    output logic                   filter_valid,
    input  logic                   filter_ready,
    output logic [DATA_BITS-1:0]   ifmap_data,
    output logic                   ifmap_valid,
    input  logic                   ifmap_ready,
    output logic [DATA_BITS-1:0]   ipsum_data,
    output logic                   ipsum_valid,
    input  logic                   ipsum_ready,
    input  logic [DATA_BITS-1:0]   opsum_data,
    input  logic                   opsum_valid,
    output logic                   opsum_ready
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CFG    = 3'd1,
        S_FILTER = 3'd2,
        S_IFMAP  = 3'd3,
        S_IPSUM  = 3'd4,
        S_OPSUM  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam logic [ADDR_BITS-1:0] ZERO_A = {ADDR_BITS{1'b0}};
    localparam logic [ADDR_BITS-1:0] ONE_A  = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t                 state_r, state_s;
    logic [CONFIG_SIZE-1:0] cfg_r;
    logic [ADDR_BITS-1:0]   filter_base_r, ifmap_base_r, ipsum_base_r, opsum_base_r;
    logic [ADDR_BITS-1:0]   pass_r;       // current pass index k
    logic [ADDR_BITS-1:0]   issued_r;     // reads issued in this phase
    logic [ADDR_BITS-1:0]   accepted_r;   // words handed over in this phase
    logic [ADDR_BITS-1:0]   ifmap_off_r;  // ifmap offsets run on across passes
    logic [ADDR_BITS-1:0]   ipsum_off_r;  // equals k*N + words read this pass
    logic [ADDR_BITS-1:0]   opsum_off_r;  // equals k*N + words written this pass
    logic                   rd_pend_r;    // a read was issued last cycle
    logic                   hold_valid_r;
    logic [DATA_BITS-1:0]   hold_data_r;

    logic [ADDR_BITS-1:0]   rs_s, u_s, n_s, f_s, phase_cnt_s, filt_cnt_s;
    logic [5:0]             p6_s, rs6_s, filt_prod_s;
    logic                   read_state_s, cur_ready_s, accept_s, last_acc_s;
    logic                   rd_en_s, op_hs_s, op_last_s, phase_done_s, latch_s;
    logic [ADDR_BITS-1:0]   rd_addr_s;

    // Decode loop bounds from the latched configuration.
    always_comb begin
        rs_s        = {{(ADDR_BITS-2){1'b0}}, cfg_r[11:10]} + ONE_A;
        u_s         = {{(ADDR_BITS-1){1'b0}}, cfg_r[9]} + ONE_A;
        f_s         = {{(ADDR_BITS-5){1'b0}}, cfg_r[6:2]};
        p6_s        = {4'b0000, cfg_r[8:7]} + 6'd1;
        rs6_s       = {4'b0000, cfg_r[11:10]} + 6'd1;
        filt_prod_s = p6_s * rs6_s;
        filt_cnt_s  = {{(ADDR_BITS-6){1'b0}}, filt_prod_s};
        if (cfg_r[12]) begin
            n_s = {{(ADDR_BITS-2){1'b0}}, cfg_r[1:0]} + ONE_A;
        end else begin
            n_s = {{(ADDR_BITS-2){1'b0}}, cfg_r[8:7]} + ONE_A;
        end
    end

    // Per-phase word count, current stream's ready and read address.
    always_comb begin
        phase_cnt_s  = ZERO_A;
        cur_ready_s  = 1'b0;
        read_state_s = 1'b0;
        rd_addr_s    = ZERO_A;
        case (state_r)
            S_FILTER: begin
                phase_cnt_s  = filt_cnt_s;
                cur_ready_s  = filter_ready;
                read_state_s = 1'b1;
                rd_addr_s    = filter_base_r + issued_r;
            end
            S_IFMAP: begin
                phase_cnt_s  = (pass_r == ZERO_A) ? rs_s : u_s;
                cur_ready_s  = ifmap_ready;
                read_state_s = 1'b1;
                rd_addr_s    = ifmap_base_r + ifmap_off_r;
            end
            S_IPSUM: begin
                phase_cnt_s  = n_s;
                cur_ready_s  = ipsum_ready;
                read_state_s = 1'b1;
                rd_addr_s    = ipsum_base_r + ipsum_off_r;
            end
            S_OPSUM: begin
                phase_cnt_s  = n_s;
            end
            default: begin
                phase_cnt_s  = ZERO_A;
            end
        endcase
    end

    // Handshake events and read issue decision (at most one read in flight).
    always_comb begin
        accept_s     = read_state_s && hold_valid_r && cur_ready_s;
        last_acc_s   = accept_s && (accepted_r == (phase_cnt_s - ONE_A));
        rd_en_s      = read_state_s && (issued_r != phase_cnt_s) && !rd_pend_r &&
                       (!hold_valid_r || accept_s);
        op_hs_s      = (state_r == S_OPSUM) && opsum_valid;
        op_last_s    = op_hs_s && (accepted_r == (n_s - ONE_A));
        phase_done_s = last_acc_s || op_last_s;
        latch_s      = (state_r == S_IDLE) && start;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE:   state_s = start ? S_CFG : S_IDLE;
            S_CFG:    state_s = S_FILTER;
            S_FILTER: state_s = last_acc_s ? S_IFMAP : S_FILTER;
            S_IFMAP:  state_s = last_acc_s ? S_IPSUM : S_IFMAP;
            S_IPSUM:  state_s = last_acc_s ? S_OPSUM : S_IPSUM;
            S_OPSUM: begin
                if (op_last_s) begin
                    state_s = (pass_r == f_s) ? S_DONE : S_IFMAP;
                end else begin
                    state_s = S_OPSUM;
                end
            end
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Capture configuration and base addresses when a command is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_r         <= {CONFIG_SIZE{1'b0}};
            filter_base_r <= ZERO_A;
            ifmap_base_r  <= ZERO_A;
            ipsum_base_r  <= ZERO_A;
            opsum_base_r  <= ZERO_A;
        end else if (latch_s) begin
            cfg_r         <= cfg;
            filter_base_r <= filter_base;
            ifmap_base_r  <= ifmap_base;
            ipsum_base_r  <= ipsum_base;
            opsum_base_r  <= opsum_base;
        end
    end

    // Phase/pass counters and running address offsets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_r      <= ZERO_A;
            issued_r    <= ZERO_A;
            accepted_r  <= ZERO_A;
            ifmap_off_r <= ZERO_A;
            ipsum_off_r <= ZERO_A;
            opsum_off_r <= ZERO_A;
        end else if (latch_s) begin
            pass_r      <= ZERO_A;
            issued_r    <= ZERO_A;
            accepted_r  <= ZERO_A;
            ifmap_off_r <= ZERO_A;
            ipsum_off_r <= ZERO_A;
            opsum_off_r <= ZERO_A;
        end else begin
            if (phase_done_s) begin
                issued_r   <= ZERO_A;
                accepted_r <= ZERO_A;
            end else begin
                if (rd_en_s) begin
                    issued_r <= issued_r + ONE_A;
                end
                if (accept_s || op_hs_s) begin
                    accepted_r <= accepted_r + ONE_A;
                end
            end
            if (rd_en_s && (state_r == S_IFMAP)) begin
                ifmap_off_r <= ifmap_off_r + ONE_A;
            end
            if (rd_en_s && (state_r == S_IPSUM)) begin
                ipsum_off_r <= ipsum_off_r + ONE_A;
            end
            if (op_hs_s) begin
                opsum_off_r <= opsum_off_r + ONE_A;
            end
            if (op_last_s && (state_s == S_IFMAP)) begin
                pass_r <= pass_r + ONE_A;
            end
        end
    end

    // Read-return capture into the single-entry hold register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend_r    <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_data_r  <= {DATA_BITS{1'b0}};
        end else if (latch_s) begin
            rd_pend_r    <= 1'b0;
            hold_valid_r <= 1'b0;
            hold_data_r  <= {DATA_BITS{1'b0}};
        end else begin
            rd_pend_r <= rd_en_s;
            if (rd_pend_r) begin
                hold_valid_r <= 1'b1;
                hold_data_r  <= rd_data;
            end else if (accept_s) begin
                hold_valid_r <= 1'b0;
            end
        end
    end

    // Output decode; everything is gated by state so reset forces all zeros.
    always_comb begin
        busy         = (state_r != S_IDLE);
        done         = (state_r == S_DONE);
        pe_en        = (state_r == S_CFG);
        pe_config    = pe_en ? cfg_r : {CONFIG_SIZE{1'b0}};
        rd_en        = rd_en_s;
        rd_addr      = rd_en_s ? rd_addr_s : ZERO_A;
        filter_valid = (state_r == S_FILTER) && hold_valid_r;
        ifmap_valid  = (state_r == S_IFMAP) && hold_valid_r;
        ipsum_valid  = (state_r == S_IPSUM) && hold_valid_r;
        filter_data  = filter_valid ? hold_data_r : {DATA_BITS{1'b0}};
        ifmap_data   = ifmap_valid ? hold_data_r : {DATA_BITS{1'b0}};
        ipsum_data   = ipsum_valid ? hold_data_r : {DATA_BITS{1'b0}};
        opsum_ready  = (state_r == S_OPSUM);
        wr_en        = op_hs_s;
        wr_addr      = op_hs_s ? (opsum_base_r + opsum_off_r) : ZERO_A;
        wr_data      = op_hs_s ? opsum_data : {DATA_BITS{1'b0}};
    end

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Self-checking bench for pe_stream_ctrl: a buffer/PE model drives random
// ready/valid traffic, and every read, hand-over and write is compared with
// sequences computed from the configuration by a loop-nest reference model.
module tb_pe_stream_ctrl;
    localparam int DW = 32;
    localparam int AW = 12;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [CW-1:0] cfg;
    logic [AW-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
    logic          busy, done, pe_en, rd_en, wr_en;
    logic [CW-1:0] pe_config;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [DW-1:0] rd_data, wr_data, filter_data, ifmap_data, ipsum_data, opsum_data;
    logic          filter_valid, ifmap_valid, ipsum_valid, opsum_valid, opsum_ready;
    logic          filter_ready, ifmap_ready, ipsum_ready;

    int n_pass = 0;
    int n_fail = 0;
    int n_chk  = 0;

    typedef struct {
        int            tag;   // 0 filter, 1 ifmap, 2 ipsum
        logic [AW-1:0] addr;
    } rd_t;

    rd_t           exp_rd[$];
    logic [AW-1:0] exp_wr[$];

    pe_stream_ctrl #(.DATA_BITS(DW), .ADDR_BITS(AW), .CONFIG_SIZE(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg(cfg),
        .filter_base(filter_base), .ifmap_base(ifmap_base),
        .ipsum_base(ipsum_base), .opsum_base(opsum_base),
        .busy(busy), .done(done), .pe_en(pe_en), .pe_config(pe_config),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .filter_data(filter_data), .filter_valid(filter_valid), .filter_ready(filter_ready),
        .ifmap_data(ifmap_data), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .ipsum_data(ipsum_data), .ipsum_valid(ipsum_valid), .ipsum_ready(ipsum_ready),
        .opsum_data(opsum_data), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready)
    );

    always #5 clk = ~clk;

    // Buffer contents: a fixed, address-unique pattern.
    function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
        return {a, 4'hA, ~a, 4'h5};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference traffic: filter block, then per pass ifmap/ipsum reads and opsum writes.
    task automatic build_model(input logic [CW-1:0] c, input logic [AW-1:0] fb, ib, pb, ob);
        int rs, u, p, q, f, n, ioff, cnt;
        rs = int'(c[11:10]) + 1;
        u  = int'(c[9]) + 1;
        p  = int'(c[8:7]) + 1;
        q  = int'(c[1:0]) + 1;
        f  = int'(c[6:2]);
        n  = c[12] ? q : p;
        ioff = 0;
        exp_rd.delete();
        exp_wr.delete();
        for (int i = 0; i < p * rs; i++) exp_rd.push_back('{0, AW'(int'(fb) + i)});
        for (int k = 0; k <= f; k++) begin
            cnt = (k == 0) ? rs : u;
            for (int j = 0; j < cnt; j++) begin
                exp_rd.push_back('{1, AW'(int'(ib) + ioff)});
                ioff++;
            end
            for (int j = 0; j < n; j++) exp_rd.push_back('{2, AW'(int'(pb) + k * n + j)});
            for (int j = 0; j < n; j++) exp_wr.push_back(AW'(int'(ob) + k * n + j));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {55'd0, busy, done, pe_en, rd_en, wr_en,
                             filter_valid, ifmap_valid, ipsum_valid, opsum_ready}, 64'd0);
        chk({tag, "_addr"}, {27'd0, pe_config, rd_addr, wr_addr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, wr_data}, 64'd0);
        chk({tag, "_sdata"}, {filter_data | ifmap_data, ipsum_data}, 64'd0);
    endtask

    task automatic run_job(input logic [CW-1:0] c, input logic [AW-1:0] fbv, ibv, pbv, obv,
                           input int rdy_pct, input bit stall, input bit inj, input bit abort);
        int            rd_idx, acc_idx, done_cnt, stall_left, inj_state, abort_cnt, sz;
        bit            pend, seen_f, finished, prev_done, op_acc;
        logic [AW-1:0] pend_a, wa;
        logic [2:0]    v, r, pv, pacc;
        logic [DW-1:0] d[3];
        logic [DW-1:0] pd[3];
        rd_idx = 0; acc_idx = 0; done_cnt = 0; stall_left = 0; inj_state = 0; abort_cnt = -1;
        pend = 1'b0; seen_f = 1'b0; finished = 1'b0; prev_done = 1'b0; op_acc = 1'b1;
        pend_a = '0; pv = 3'b000; pacc = 3'b000;
        for (int s = 0; s < 3; s++) pd[s] = '0;
        build_model(c, fbv, ibv, pbv, obv);
        sz = exp_rd.size();
        for (int cyc = 0; cyc < 6000 && !finished; cyc++) begin
            @(negedge clk);
            if (abort_cnt == 0) begin
                chk("busy_before_abort", {63'd0, busy}, 64'd1);
                rst = 1'b1;
                #1;
                check_reset_outputs("abort_rst");
                start = 1'b0;
                return;
            end
            start = (cyc == 0) || (inj_state == 1);
            if (inj_state == 1) begin
                cfg = c ^ 13'h1FFF;
                filter_base = ~fbv; ifmap_base = ~ibv; ipsum_base = ~pbv; opsum_base = ~obv;
                inj_state = 2;
            end else begin
                cfg = c;
                filter_base = fbv; ifmap_base = ibv; ipsum_base = pbv; opsum_base = obv;
            end
            rd_data      = pend ? memf(pend_a) : DW'($urandom);
            filter_ready = ($urandom_range(0, 99) < rdy_pct);
            ifmap_ready  = ($urandom_range(0, 99) < rdy_pct);
            ipsum_ready  = ($urandom_range(0, 99) < rdy_pct);
            if (stall && (!seen_f || stall_left > 0)) begin
                filter_ready = 1'b0;
                if (seen_f) stall_left--;
            end
            if (op_acc) begin
                opsum_valid = ($urandom_range(0, 99) < rdy_pct);
                opsum_data  = DW'($urandom);
            end
            #1;
            if (cyc == 0) chk("idle_before_start", {63'd0, busy}, 64'd0);
            v = {ipsum_valid, ifmap_valid, filter_valid};
            r = {ipsum_ready, ifmap_ready, filter_ready};
            d[0] = filter_data; d[1] = ifmap_data; d[2] = ipsum_data;
            for (int s = 0; s < 3; s++) begin
                if (pv[s] && !pacc[s]) begin
                    chk("valid_held", {63'd0, v[s]}, 64'd1);
                    chk("data_held", {32'd0, d[s]}, {32'd0, pd[s]});
                end
                if (v[s]) chk("valid_stream", s, (acc_idx < sz) ? exp_rd[acc_idx].tag : -1);
            end
            if (rd_en) begin
                chk("rd_outstanding", {63'd0, pend}, 64'd0);
                chk("rd_while_pending", {61'd0, v & ~r}, 64'd0);
                if (rd_idx < sz) chk("rd_addr", {52'd0, rd_addr}, {52'd0, exp_rd[rd_idx].addr});
                else chk("rd_extra", rd_idx, sz);
                rd_idx++;
            end
            pend   = rd_en;
            pend_a = rd_addr;
            for (int s = 0; s < 3; s++) begin
                if (v[s] && r[s]) begin
                    if (acc_idx < sz) begin
                        chk("acc_tag", s, exp_rd[acc_idx].tag);
                        chk("acc_data", {32'd0, d[s]}, {32'd0, memf(exp_rd[acc_idx].addr)});
                    end else begin
                        chk("acc_extra", acc_idx, sz);
                    end
                    acc_idx++;
                end
            end
            if (opsum_valid && opsum_ready) begin
                chk("wr_en", {63'd0, wr_en}, 64'd1);
                chk("wr_data", {32'd0, wr_data}, {32'd0, opsum_data});
                if (exp_wr.size() > 0) begin
                    wa = exp_wr.pop_front();
                    chk("wr_addr", {52'd0, wr_addr}, {52'd0, wa});
                end else begin
                    chk("wr_extra", 64'd1, 64'd0);
                end
            end else begin
                chk("wr_idle", {63'd0, wr_en}, 64'd0);
            end
            op_acc = !opsum_valid || opsum_ready;
            if (stall && !seen_f && filter_valid) begin
                seen_f = 1'b1;
                stall_left = 4;
            end
            if (inj && inj_state == 0 && ifmap_valid) inj_state = 1;
            if (abort && abort_cnt < 0 && ifmap_valid) abort_cnt = 1;
            else if (abort_cnt > 0) abort_cnt--;
            if (prev_done) begin
                chk("busy_after_done", {63'd0, busy}, 64'd0);
                finished = 1'b1;
            end
            if (done) begin
                done_cnt++;
                chk("busy_at_done", {63'd0, busy}, 64'd1);
            end
            prev_done = done;
            pv = v;
            pacc = v & r;
            pd = d;
        end
        chk("job_finished", {63'd0, finished}, 64'd1);
        chk("rd_count", rd_idx, sz);
        chk("acc_count", acc_idx, sz);
        chk("wr_left", exp_wr.size(), 0);
        chk("done_count", done_cnt, 1);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg = '0;
        filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
        rd_data = '0; opsum_data = '0; opsum_valid = 1'b0;
        filter_ready = 1'b0; ifmap_ready = 1'b0; ipsum_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;

        // Minimal job: one word per stream, single pass.
        run_job(13'h0000, 12'd0, 12'd16, 12'd32, 12'd48, 100, 1'b0, 1'b0, 1'b0);
        // rs=3, p=2, U=1, F=2.
        run_job(13'h0888, 12'd100, 12'd200, 12'd300, 12'd400, 100, 1'b0, 1'b0, 1'b0);
        // Filter consumer stalls with a word pending.
        run_job(13'h0888, 12'd10, 12'd20, 12'd30, 12'd40, 100, 1'b1, 1'b0, 1'b0);
        // Second start during IFMAP must be ignored.
        run_job(13'h0888, 12'd500, 12'd600, 12'd700, 12'd800, 100, 1'b0, 1'b1, 1'b0);
        // Depthwise, q=3, p=1, rs=2, F=1.
        run_job(13'h1406, 12'd50, 12'd60, 12'd70, 12'd80, 70, 1'b0, 1'b0, 1'b0);
        // Address wrap at the top of the buffer.
        run_job(13'h0888, 12'hFFE, 12'hFFD, 12'hFFC, 12'hFFB, 60, 1'b0, 1'b0, 1'b0);
        // Reset mid-IFMAP, then the minimal job must replay exactly.
        run_job(13'h0888, 12'd1, 12'd2, 12'd3, 12'd4, 100, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run_job(13'h0000, 12'd0, 12'd16, 12'd32, 12'd48, 100, 1'b0, 1'b0, 1'b0);
        // Random configurations, bases and back-pressure.
        for (int j = 0; j < 6; j++) begin
            run_job(CW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom),
                    int'($urandom_range(30, 100)), 1'b0, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pe_stream_ctrl.md
PE_STREAM_CTRL -- requirements
Module: pe_stream_ctrl

Interface
REQ-001 Parameters (name, default, meaning): DATA_BITS, 32, word width; ADDR_BITS, 12, GLB word address width; CONFIG_SIZE, 13, PE config width.
REQ-002 clk  in  1  clock, rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 start  in  1  one-cycle command pulse; honoured only in IDLE.
REQ-005 cfg  in  CONFIG_SIZE  PE config; fields: [12] depthwise, [11:10] rs-1, [9] U-1, [8:7] p-1, [6:2] F, [1:0] q-1.
REQ-006 filter_base, ifmap_base, ipsum_base, opsum_base  in  ADDR_BITS each  GLB word base addresses.
REQ-007 busy  out  1  high whenever state is not IDLE; done  out  1  one-cycle completion pulse.
REQ-008 pe_en  out  1  PE enable pulse; pe_config  out  CONFIG_SIZE  config presented to the PE.
REQ-009 rd_en  out  1; rd_addr  out  ADDR_BITS; rd_data  in  DATA_BITS  GLB read port, data valid the cycle after rd_en.
REQ-010 wr_en  out  1; wr_addr  out  ADDR_BITS; wr_data  out  DATA_BITS  GLB write port, always accepts.
REQ-011 filter_data/ifmap_data/ipsum_data  out  DATA_BITS; filter_valid/ifmap_valid/ipsum_valid  out  1; filter_ready/ifmap_ready/ipsum_ready  in  1  PE input streams.
REQ-012 opsum_data  in  DATA_BITS; opsum_valid  in  1; opsum_ready  out  1  PE output stream.

Function
REQ-013 Decode from latched cfg: rs=cfg[11:10]+1, U=cfg[9]+1, p=cfg[8:7]+1, q=cfg[1:0]+1, F=cfg[6:2]; N=q if depthwise else p.
REQ-014 States: IDLE, CFG, FILTER, IFMAP, IPSUM, OPSUM, DONE.
REQ-015 IDLE->CFG on start; cfg and four bases latched at that edge; start in any other state ignored.
REQ-016 CFG lasts exactly one cycle with pe_en=1 and pe_config=latched cfg; then FILTER.
REQ-017 FILTER streams p*rs words from filter_base+0 upward; IFMAP then IPSUM then OPSUM form one pass.
REQ-018 Pass k (k=0..F) ifmap word count: rs for k=0, U for k>0; ifmap addresses continue consecutively from ifmap_base across passes (pass k starts at ifmap_base+rs+(k-1)*U).
REQ-019 Pass k ipsum: N words from ipsum_base+k*N; opsum: N words written to opsum_base+k*N upward.
REQ-020 OPSUM->IFMAP after N opsum handshakes when k<F; ->DONE when k==F; DONE lasts one cycle with done=1, then IDLE.
REQ-021 Read streaming (FILTER/IFMAP/IPSUM): one outstanding read max; rd_en issued when words remain and hold register empty or its word is accepted that cycle; rd_data captured into hold register at the edge after the rd_en cycle; *_valid driven from hold-valid; steady-state rate one word per 2 cycles.
REQ-022 Handshake: word transfers when valid&&ready at a rising edge; valid and data held stable until accepted; valid never asserted on a stream other than the current state's.
REQ-023 State advances the cycle after the last word of the phase is accepted; no reads issued past phase count.
REQ-024 opsum_ready=1 only in OPSUM; each opsum_valid&&opsum_ready produces wr_en=1, wr_data=opsum_data, wr_addr=current opsum address, combinationally in that cycle.
REQ-025 Address and word counters ADDR_BITS wide, wrap modulo 2^ADDR_BITS without error.
REQ-026 F=0: exactly one pass, then DONE.

Reset
REQ-027 rst asserted (any time, including mid-phase): state IDLE, all counters, hold register and latched cfg cleared; busy, done, pe_en, rd_en, wr_en, all *_valid, opsum_ready =0; pe_config, rd_addr, wr_addr, wr_data, *_data =0.
REQ-028 After rst release, next start begins from the newly latched bases with no residual state.

Verification
REQ-029 cfg p=1,q=1,rs=1,F=0, bases 0/16/32/48, PE always ready -> reads 0,16,32; one write at 48; done one cycle; busy falls next cycle.
REQ-030 cfg rs=3,p=2,U=1,F=2, non-depthwise -> 6 filter reads, ifmap reads base+0..4 (3,1,1), 6 ipsum reads, 6 writes to opsum_base+0..5 in order.
REQ-031 filter_ready low 5 cycles with word pending -> filter_valid and filter_data stable, no further rd_en until acceptance.
REQ-032 start pulsed in IFMAP with different cfg -> ignored; sequence completes with original cfg.
REQ-033 rst asserted mid-IFMAP -> all outputs 0 same cycle; subsequent start reproduces REQ-029 traffic exactly.
REQ-034 depthwise=1, q=3, p=1, F=1 -> 3 ipsum reads and 3 opsum writes per pass, opsum addresses base+0..5.
